// File: rtl/if_id_queue.sv
// IF/ID instruction queue: small FIFO between fetch and decode with head decode.
// Optional IF_ID_QUEUE_STALL_CNT_EN adds a saturating decode-stall counter.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
`ifdef IF_ID_QUEUE_STALL_CNT_EN
  output logic [15:0]     stall_cnt,
`endif
  output logic            illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PC_W+31:0] mem_q [DEPTH];

  logic push;
  logic pop;
  logic op_ok;

  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is unreset; outputs are masked to a NOP whenever empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_pc, in_instr};
  end

  always_comb begin
    out_pc    = '0;
    out_instr = NOP;
    if (out_valid) begin
      out_pc    = mem_q[rd_ptr_q][PC_W+31:32];
      out_instr = mem_q[rd_ptr_q][31:0];
    end
  end

  assign opcode = out_instr[6:0];
  assign rd     = out_instr[11:7];
  assign funct3 = out_instr[14:12];
  assign rs1    = out_instr[19:15];
  assign rs2    = out_instr[24:20];
  assign funct7 = out_instr[31:25];

  always_comb begin
    op_ok = 1'b0;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0000011,
      7'b0100011, 7'b1100011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111,
      7'b1110011, 7'b0001111: op_ok = 1'b1;
      default:                op_ok = 1'b0;
    endcase
  end

  assign illegal = out_valid &&
                   ((out_instr[1:0] != 2'b11) || !op_ok);

`ifdef IF_ID_QUEUE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Flush does not clear the counter; only reset does.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue.
// Covers IF_ID_QUEUE_STALL_CNT_EN when that macro is defined.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic        illegal;
`ifdef IF_ID_QUEUE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(2), .PC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .opcode    (opcode),
    .rd        (rd),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct7    (funct7),
`ifdef IF_ID_QUEUE_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .illegal   (illegal)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] pc,
                       input logic [31:0] ins, input logic rdy,
                       input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0000_0013);
    check("rst_out_pc", 32'(out_pc), 32'h0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_opcode", 32'(opcode), 32'h13);

    // addi x1,x0,5
    drive(1'b1, 8'h04, 32'h0050_0093, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    check("p1_out_valid", 32'(out_valid), 32'd1);
    check("p1_opcode", 32'(opcode), 32'h13);
    check("p1_rd", 32'(rd), 32'd1);
    check("p1_rs1", 32'(rs1), 32'd0);
    check("p1_funct3", 32'(funct3), 32'd0);
    check("p1_illegal", 32'(illegal), 32'd0);
    check("p1_out_pc", 32'(out_pc), 32'h04);
    check("p1_in_ready", 32'(in_ready), 32'd1);

    // count==1: simultaneous push and pop
    drive(1'b1, 8'h08, 32'h00A0_0113, 1'b1, 1'b0);
    step();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    check("pp_out_valid", 32'(out_valid), 32'd1);
    check("pp_out_instr", out_instr, 32'h00A0_0113);
    check("pp_out_pc", 32'(out_pc), 32'h08);
    check("pp_in_ready", 32'(in_ready), 32'd1);
    check("pp_rd", 32'(rd), 32'd2);

    // fill to full
    drive(1'b1, 8'h0C, 32'h0020_81B3, 1'b0, 1'b0);
    step();
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head_pc", 32'(out_pc), 32'h08);

    // full: push attempt with pop in same cycle is ignored
    drive(1'b1, 8'h10, 32'h0000_007F, 1'b1, 1'b0);
    step();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    check("pop2_out_pc", 32'(out_pc), 32'h0C);
    check("pop2_out_instr", out_instr, 32'h0020_81B3);
    check("pop2_rd", 32'(rd), 32'd3);
    check("pop2_rs1", 32'(rs1), 32'd1);
    check("pop2_rs2", 32'(rs2), 32'd2);
    check("pop2_opcode", 32'(opcode), 32'h33);
    check("pop2_in_ready", 32'(in_ready), 32'd1);

    drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    step();
    check("empty_out_valid", 32'(out_valid), 32'd0);
    check("empty_out_instr", out_instr, 32'h0000_0013);
    check("empty_out_pc", 32'(out_pc), 32'h0);

    // illegal entries
    drive(1'b1, 8'h10, 32'h0000_007F, 1'b0, 1'b0);
    step();
    check("ill1_illegal", 32'(illegal), 32'd1);
    check("ill1_opcode", 32'(opcode), 32'h7F);
    drive(1'b1, 8'h14, 32'h0000_0000, 1'b0, 1'b0);
    step();
    check("ill1_still", 32'(illegal), 32'd1);
    check("ill_full", 32'(in_ready), 32'd0);
    drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    step();
    check("ill2_illegal", 32'(illegal), 32'd1);
    check("ill2_out_pc", 32'(out_pc), 32'h14);
    check("ill2_out_instr", out_instr, 32'h0);
    step();
    check("ill_done_valid", 32'(out_valid), 32'd0);
    check("ill_done_illegal", 32'(illegal), 32'd0);

    // sub x3,x1,x2 then lw, then flush with in_valid
    drive(1'b1, 8'h20, 32'h4020_81B3, 1'b0, 1'b0);
    step();
    check("sub_funct7", 32'(funct7), 32'h20);
    drive(1'b1, 8'h24, 32'h0000_2083, 1'b0, 1'b0);
    step();
    check("fl_pre_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 8'h28, 32'h0050_0093, 1'b1, 1'b1);
    step();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    check("fl_out_instr", out_instr, 32'h0000_0013);
    check("fl_out_pc", 32'(out_pc), 32'h0);

    // queue works from cleared pointers after flush
    drive(1'b1, 8'h30, 32'h0000_2083, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    check("afl_out_pc", 32'(out_pc), 32'h30);
    check("afl_opcode", 32'(opcode), 32'h03);
    check("afl_funct3", 32'(funct3), 32'd2);

    // reset mid-operation wins over push
    rst = 1'b1;
    drive(1'b1, 8'h34, 32'h0050_0093, 1'b1, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);

`ifdef IF_ID_QUEUE_STALL_CNT_EN
    check("sc_reset", 32'(stall_cnt), 32'd0);
    drive(1'b1, 8'h40, 32'h0050_0093, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    check("sc_zero", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("sc_five", 32'(stall_cnt), 32'd5);
    drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b1);
    step();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    check("sc_flush", 32'(stall_cnt), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("sc_rst", 32'(stall_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of queue entries (power of two, at least 2).
REQ-002 The block SHALL have parameter PC_W, default 8, meaning the PC/address width, matching the fetch stage.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1: the fetch stage presents an instruction.
REQ-006 The block SHALL have port in_ready, output, 1: the queue can accept an instruction this cycle.
REQ-007 The block SHALL have port in_pc, input, PC_W: the address of the fetched instruction.
REQ-008 The block SHALL have port in_instr, input, 32: the fetched instruction word.
REQ-009 The block SHALL have port flush, input, 1: discard all queued and incoming instructions (taken jump/branch).
REQ-010 The block SHALL have port out_valid, output, 1: the head entry is valid for decode.
REQ-011 The block SHALL have port out_ready, input, 1: decode consumes the head entry.
REQ-012 The block SHALL have port out_pc, output, PC_W: the PC of the head entry.
REQ-013 The block SHALL have port out_instr, output, 32: the head instruction word.
REQ-014 The block SHALL have ports opcode (7), rd (5), funct3 (3), rs1 (5), rs2 (5) and funct7 (7), all outputs, giving head fields [6:0], [11:7], [14:12], [19:15], [24:20] and [31:25].
REQ-015 The block SHALL have port illegal, output, 1: the head is valid and its opcode is not RV32I.

Function
REQ-016 A push SHALL occur when in_valid && in_ready && !flush; a pop SHALL occur when out_valid && out_ready && !flush.
REQ-017 in_ready SHALL equal (count < DEPTH), registered-state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (count != 0).
REQ-019 Latency SHALL be one cycle: an entry pushed at edge N is visible at out_* after edge N.
REQ-020 Order SHALL be FIFO; pointers SHALL wrap modulo DEPTH.
REQ-021 A push and pop in the same cycle SHALL leave count unchanged, including when count==1.
REQ-022 When full, in_valid SHALL be ignored even if out_ready is high in the same cycle.
REQ-023 When empty, out_instr SHALL read 0x00000013 (NOP), out_pc SHALL read 0, and the decoded fields SHALL derive from that NOP.
REQ-024 flush SHALL clear count and both pointers at the next edge, overriding any push or pop in that cycle.
REQ-025 illegal SHALL be 1 iff out_valid and (out_instr[1:0] != 2'b11 or opcode is not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011, 0001111}).
REQ-026 The queue SHALL NOT alter illegal entries; they SHALL still pop normally.

Reset
REQ-027 While rst is high at an edge, count, rd_ptr and wr_ptr SHALL become 0 and the stall counter SHALL become 0.
REQ-028 After reset, in_ready=1, out_valid=0, out_instr=0x00000013, out_pc=0 and illegal=0.
REQ-029 rst SHALL take priority over flush, push and pop; entries in flight mid-operation SHALL be discarded.
REQ-030 Entry storage SHALL need no reset; no stale data SHALL be observable while count==0.

Configuration
REQ-031 Macro IF_ID_QUEUE_STALL_CNT_EN, when defined, SHALL add output stall_cnt (16 bits), which increments on each cycle with out_valid && !out_ready, saturates at 0xFFFF, and clears on rst only, not on flush.
REQ-032 Without IF_ID_QUEUE_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then push pc=0x04 instr=0x00500093 with out_ready=0 -> next cycle out_valid=1, opcode=0x13, rd=1, rs1=0, illegal=0.
REQ-034 Push 0x00A00113 and 0x002081B3 with out_ready=0 -> in_ready=0 after the 2nd push; a 3rd in_valid is ignored; pops return the entries in order with pc 0x08, 0x0C.
REQ-035 count==1, simultaneous push and pop -> count remains 1 and the head becomes the new entry next cycle.
REQ-036 Full queue, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_instr=0x00000013.
REQ-037 Push 0x0000007F -> illegal=1 while it is the head; push 0x00000000 -> illegal=1 (bits[1:0]=00).
REQ-038 With IF_ID_QUEUE_STALL_CNT_EN: hold one entry with out_ready=0 for 5 cycles -> stall_cnt=5; a flush leaves it at 5; rst clears it to 0.
